// File: rtl/register_file_pkg.sv
// Shared register-file constants for the HybridCore operand-fetch / writeback path.
package register_file_pkg;
  localparam int   RF_DATA_W           = 16;
  localparam int   RF_REG_IDX_W        = 5;
  localparam int   RF_NUM_REGS         = 2 ** RF_REG_IDX_W;
  localparam logic ADDR_MODE_DIRECT    = 1'b0;
  localparam logic ADDR_MODE_IMMEDIATE = 1'b1;
endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, hazard detect for both read ports.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int REG_IDX_W = RF_REG_IDX_W,
  parameter int ZERO_REG  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rsv_en,
  input  logic [REG_IDX_W-1:0] rsv_idx,
  input  logic                 w_en,
  input  logic [REG_IDX_W-1:0] w_idx,
  input  logic                 r_en_a,
  input  logic [REG_IDX_W-1:0] r_idx_a,
  input  logic                 r_en_b,
  input  logic [REG_IDX_W-1:0] r_idx_b,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic                 pending_any
);
  localparam int NUM_REGS = 2 ** REG_IDX_W;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                rsv_ok;

  // Register 0 never becomes pending when it is hardwired to zero.
  assign rsv_ok = !((ZERO_REG != 0) && (rsv_idx == '0));

  // Next pending vector: clear on writeback, then set on reserve so a new producer wins.
  always_comb begin
    pending_nxt = pending;
    if (w_en) pending_nxt[w_idx] = 1'b0;
    if (rsv_en && rsv_ok) pending_nxt[rsv_idx] = 1'b1;
  end

  // Scoreboard state; pending_any summarises the vector one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      pending_any <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      pending_any <= |pending;
    end
  end

  // A read is hazardous unless the pending value is arriving on the write port right now.
  assign hazard_a = r_en_a & pending[r_idx_a] & ~(w_en & (w_idx == r_idx_a));
  assign hazard_b = r_en_b & pending[r_idx_b] & ~(w_en & (w_idx == r_idx_b));
endmodule

// File: rtl/register_file.sv
// Architectural register file: two registered read ports with write-first bypass,
// one write port, and a pending-writeback scoreboard for operand-fetch stalls.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int REG_IDX_W = RF_REG_IDX_W,
  parameter int ZERO_REG  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_r_en_a,
  input  logic [15:0]          reg_r_idx_a,
  output logic [DATA_W-1:0]    reg_r_data_a,
  input  logic                 reg_r_en_b,
  input  logic [15:0]          reg_r_idx_b,
  output logic [DATA_W-1:0]    reg_r_data_b,
  input  logic                 reg_w_en,
  input  logic [15:0]          reg_w_idx,
  input  logic [DATA_W-1:0]    reg_w_data,
  input  logic                 rsv_en,
  input  logic [REG_IDX_W-1:0] rsv_idx,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic                 pending_any
);
  localparam int NUM_REGS = 2 ** REG_IDX_W;

  logic [DATA_W-1:0]    mem [NUM_REGS];
  logic [REG_IDX_W-1:0] idx_a;
  logic [REG_IDX_W-1:0] idx_b;
  logic [REG_IDX_W-1:0] idx_w;
  logic                 w_ok;
  logic                 unused_idx_bits;

  assign idx_a = reg_r_idx_a[REG_IDX_W-1:0];
  assign idx_b = reg_r_idx_b[REG_IDX_W-1:0];
  assign idx_w = reg_w_idx[REG_IDX_W-1:0];
  assign unused_idx_bits = ^{reg_r_idx_a[15:REG_IDX_W], reg_r_idx_b[15:REG_IDX_W],
                             reg_w_idx[15:REG_IDX_W]};

  // Writes to a hardwired-zero register 0 are dropped, so mem[0] stays 0 and the bypass never fires for it.
  assign w_ok = reg_w_en && !((ZERO_REG != 0) && (idx_w == '0));

  // Storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (w_ok) begin
      mem[idx_w] <= reg_w_data;
    end
  end

  // Read-data registers with write-first bypass; hold when the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_r_data_a <= '0;
      reg_r_data_b <= '0;
    end else begin
      if (reg_r_en_a) reg_r_data_a <= (w_ok && idx_w == idx_a) ? reg_w_data : mem[idx_a];
      if (reg_r_en_b) reg_r_data_b <= (w_ok && idx_w == idx_b) ? reg_w_data : mem[idx_b];
    end
  end

  reg_scoreboard #(
    .REG_IDX_W (REG_IDX_W),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rsv_en      (rsv_en),
    .rsv_idx     (rsv_idx),
    .w_en        (reg_w_en),
    .w_idx       (idx_w),
    .r_en_a      (reg_r_en_a),
    .r_idx_a     (idx_a),
    .r_en_b      (reg_r_en_b),
    .r_idx_b     (idx_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .pending_any (pending_any)
  );
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file (ZERO_REG = 1): directed cases plus randomized traffic
// against an array-based reference model, with a queue-fed output monitor.
module tb_register_file;
  localparam int ZR = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_r_en_a, reg_r_en_b, reg_w_en, rsv_en;
  logic [15:0] reg_r_idx_a, reg_r_idx_b, reg_w_idx, reg_w_data;
  logic [4:0]  rsv_idx;
  logic [15:0] reg_r_data_a, reg_r_data_b;
  logic        hazard_a, hazard_b, pending_any;

  register_file #(.DATA_W(16), .REG_IDX_W(5), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset),
    .reg_r_en_a(reg_r_en_a), .reg_r_idx_a(reg_r_idx_a), .reg_r_data_a(reg_r_data_a),
    .reg_r_en_b(reg_r_en_b), .reg_r_idx_b(reg_r_idx_b), .reg_r_data_b(reg_r_data_b),
    .reg_w_en(reg_w_en), .reg_w_idx(reg_w_idx), .reg_w_data(reg_w_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [15:0] a;
    logic [15:0] b;
    logic        pany;
  } exp_t;
  exp_t q[$];

  // Reference model state.
  logic [15:0] m_mem [32];
  bit          m_pend [32];
  logic [15:0] m_out_a, m_out_b;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: registered outputs become visible after the edge the entry is due on.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_a", reg_r_data_a, e.a);
      chk("rd_b", reg_r_data_b, e.b);
      chk("pending_any", {15'd0, pending_any}, {15'd0, e.pany});
    end
  end

  function automatic bit any_pending();
    for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus: drive, check combinational hazards, predict, advance model.
  task automatic drv(input bit rst, input bit ea, input logic [15:0] ia,
                     input bit eb, input logic [15:0] ib,
                     input bit we, input logic [15:0] wi, input logic [15:0] wd,
                     input bit rs, input logic [4:0] ri);
    int   a5, b5, w5, r5;
    bit   wv;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; reg_r_en_a = ea; reg_r_idx_a = ia; reg_r_en_b = eb; reg_r_idx_b = ib;
    reg_w_en = we; reg_w_idx = wi; reg_w_data = wd; rsv_en = rs; rsv_idx = ri;
    a5 = int'(ia % 32); b5 = int'(ib % 32); w5 = int'(wi % 32); r5 = int'(ri);
    #1;
    chk("hazard_a", {15'd0, hazard_a}, {15'd0, ea && m_pend[a5] && !(we && w5 == a5)});
    chk("hazard_b", {15'd0, hazard_b}, {15'd0, eb && m_pend[b5] && !(we && w5 == b5)});
    e.due = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 16'h0; m_pend[i] = 1'b0; end
      m_out_a = 16'h0; m_out_b = 16'h0;
      e.pany = 1'b0;
    end else begin
      wv = we && !(ZR != 0 && w5 == 0);
      e.pany = any_pending();
      if (ea) m_out_a = (wv && w5 == a5) ? wd : m_mem[a5];
      if (eb) m_out_b = (wv && w5 == b5) ? wd : m_mem[b5];
      if (wv) m_mem[w5] = wd;
      if (we) m_pend[w5] = 1'b0;
      if (rs && !(ZR != 0 && r5 == 0)) m_pend[r5] = 1'b1;
    end
    e.a = m_out_a; e.b = m_out_b;
    q.push_back(e);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; reg_r_en_a = 0; reg_r_en_b = 0; reg_w_en = 0; rsv_en = 0;
    reg_r_idx_a = 0; reg_r_idx_b = 0; reg_w_idx = 0; reg_w_data = 0; rsv_idx = 0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 16'hx; m_pend[i] = 1'b0; end
    m_out_a = 16'hx; m_out_b = 16'hx;

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset clears stored data and pending state
    drv(0, 0, 0, 0, 0, 1, 16'd3, 16'hBEEF, 1, 5'd6);
    drv(1, 1, 16'd3, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 16'd3, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // write then dual read of the same register
    drv(0, 0, 0, 0, 0, 1, 16'd5, 16'h1234, 0, 0);
    drv(0, 1, 16'd5, 1, 16'd5, 0, 0, 0, 0, 0);
    // write-first bypass on port A
    drv(0, 0, 0, 0, 0, 1, 16'd7, 16'h0001, 0, 0);
    drv(0, 1, 16'd7, 0, 0, 1, 16'd7, 16'hA5A5, 0, 0);
    // scoreboard: reserve, hazard, cleared by writeback
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    drv(0, 1, 16'd9, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 16'd9, 1, 16'd9, 1, 16'd9, 16'h0042, 0, 0);
    drv(0, 1, 16'd9, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // reserve and write collide: bit stays set
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
    drv(0, 0, 0, 0, 0, 1, 16'd4, 16'h0011, 1, 5'd4);
    drv(0, 1, 16'd4, 1, 16'd4, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 16'd4, 16'h0012, 0, 0);
    // hardwired zero register and index truncation
    drv(0, 0, 0, 0, 0, 1, 16'd0, 16'hFFFF, 1, 5'd0);
    drv(0, 1, 16'd0, 1, 16'hFFE0, 1, 16'h0020, 16'h7777, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 16'h0023, 16'h3333, 0, 0);
    drv(0, 1, 16'd3, 1, 16'h0023, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic, biased to a few registers to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      logic [15:0] ia, ib, wi;
      ia = {$urandom_range(0, 2047), 5'($urandom_range(0, 7))};
      ib = {$urandom_range(0, 2047), 5'($urandom_range(0, 7))};
      wi = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {$urandom_range(0, 2047), 5'($urandom_range(0, 7))};
      drv($urandom_range(0, 63) == 0,
          $urandom_range(0, 1) == 1, ia,
          $urandom_range(0, 1) == 1, ib,
          $urandom_range(0, 2) != 0, wi, 16'($urandom),
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 9)));
    end

    idle();
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
